// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one memory port between fetch and data stages,
// with flushed-fetch discard and a mem_ready watchdog.
module mem_port_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_valid,
  output logic [31:0] dm_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        err
);
  localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CW-1:0] LIM = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;
  state_t state, state_n;
  logic last_dm, last_dm_n, discard, discard_n;
  logic [CW-1:0] cnt, cnt_n;
  logic mem_req_n, mem_we_n, if_valid_n, dm_valid_n, err_n;
  logic [31:0] mem_addr_n, mem_wdata_n, if_rdata_n, dm_rdata_n;
  logic el_if, el_dm, pick_dm;
  // A requester whose valid is high this cycle just completed and is masked.
  assign el_if = if_req & ~if_valid & ~if_flush;
  assign el_dm = dm_req & ~dm_valid;
  assign pick_dm = el_dm & (~el_if | ~last_dm);
  always_comb begin
    state_n = state;
    last_dm_n = last_dm;
    discard_n = discard;
    cnt_n = cnt;
    mem_req_n = mem_req;
    mem_we_n = mem_we;
    mem_addr_n = mem_addr;
    mem_wdata_n = mem_wdata;
    if_rdata_n = if_rdata;
    dm_rdata_n = dm_rdata;
    if_valid_n = 1'b0;
    dm_valid_n = 1'b0;
    err_n = 1'b0;
    if (state == IDLE) begin
      if (el_if | el_dm) begin
        state_n = pick_dm ? BUSY_DM : BUSY_IF;
        last_dm_n = pick_dm;
        discard_n = 1'b0;
        cnt_n = '0;
        mem_req_n = 1'b1;
        mem_addr_n = pick_dm ? dm_addr : if_addr;
        mem_we_n = pick_dm & dm_we;
        mem_wdata_n = pick_dm ? dm_wdata : mem_wdata;
      end
    end else if (mem_ready) begin
      state_n = IDLE;
      mem_req_n = 1'b0;
      mem_we_n = 1'b0;
      discard_n = 1'b0;
      if_valid_n = (state == BUSY_IF) & ~(discard | if_flush);
      dm_valid_n = state == BUSY_DM;
      if_rdata_n = if_valid_n ? mem_rdata : if_rdata;
      dm_rdata_n = ((state == BUSY_DM) & ~mem_we) ? mem_rdata : dm_rdata;
    end else if (TIMEOUT != 0 && cnt == LIM) begin
      state_n = IDLE;
      mem_req_n = 1'b0;
      mem_we_n = 1'b0;
      discard_n = 1'b0;
      err_n = 1'b1;
    end else begin
      cnt_n = cnt + 1'b1;
      discard_n = discard | ((state == BUSY_IF) & if_flush);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last_dm <= 1'b0;
      discard <= 1'b0;
      cnt <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      if_valid <= 1'b0;
      if_rdata <= '0;
      dm_valid <= 1'b0;
      dm_rdata <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      last_dm <= last_dm_n;
      discard <= discard_n;
      cnt <= cnt_n;
      mem_req <= mem_req_n;
      mem_we <= mem_we_n;
      mem_addr <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      if_valid <= if_valid_n;
      if_rdata <= if_rdata_n;
      dm_valid <= dm_valid_n;
      dm_rdata <= dm_rdata_n;
      err <= err_n;
    end
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-ported unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage core. Each requester holds a level request. The arbiter grants one request at a time, drives the memory port with registered address and data, and returns a one-cycle valid pulse carrying read data to the owner. It also handles discarding of flushed fetches, fair arbitration, and a memory-timeout watchdog. It sits between `stage_fetch`/`stage_memory` and the memory model.

## Interface
- `TIMEOUT`, 255: maximum cycles waiting for `mem_ready` before abort; 0 disables the watchdog.
- `clk`  in  1  core clock, single clock domain.
- `reset`  in  1  synchronous, active-high.
- `if_req`  in  1  fetch read request; held until `if_valid` or `if_flush`.
- `if_addr`  in  32  fetch address; stable while `if_req`.
- `if_flush`  in  1  pulse; branch taken, so the outstanding or pending fetch is abandoned.
- `if_valid`  out  1  one-cycle pulse; `if_rdata` is valid.
- `if_rdata`  out  32  instruction word.
- `dm_req`  in  1  data request; held until `dm_valid`.
- `dm_we`  in  1  1 = store, 0 = load.
- `dm_addr`  in  32  data address.
- `dm_wdata`  in  32  store data.
- `dm_valid`  out  1  one-cycle pulse; transaction complete.
- `dm_rdata`  out  32  load data; holds its previous value on stores.
- `mem_req`  out  1  memory transaction active.
- `mem_we`  out  1  write enable to memory.
- `mem_addr`  out  32  registered address.
- `mem_wdata`  out  32  registered write data.
- `mem_ready`  in  1  memory completes the current transaction this cycle.
- `mem_rdata`  in  32  read data, valid when `mem_ready`.
- `err`  out  1  one-cycle pulse; watchdog abort.

## Operation
- FSM states:
  - IDLE
  - BUSY_IF
  - BUSY_DM
- IDLE, arbitration:
  - Eligible requesters are those with `req`=1 and `valid`=0 in this cycle. This masks the owner that just completed, whose request is still high for one cycle.
  - One eligible requester: it is granted.
  - Both eligible: round-robin on `last_grant`; the requester not granted last wins. `last_grant` resets to IF, so DM wins the first tie.
  - Fetch is not eligible in a cycle where `if_flush`=1.
- Grant: register `mem_addr` and `mem_we`/`mem_wdata` from the winner (fetch forces `mem_we`=0), set `mem_req`=1, update `last_grant`, clear the watchdog counter, and go to BUSY_IF or BUSY_DM.
- BUSY_x with `mem_ready`=1:
  - Capture `mem_rdata` into the owner's rdata (DM loads only).
  - Pulse the owner's valid.
  - Set `mem_req`=0, `mem_we`=0, and return to IDLE.
- `if_flush` in BUSY_IF, or in the same cycle as the grant to IF:
  - Set the `discard` flag.
  - The memory transaction still completes; on `mem_ready`, `if_valid` is suppressed and `if_rdata` is not updated.
  - `discard` clears on return to IDLE.
- `if_flush` in BUSY_DM or IDLE has no effect beyond the IDLE eligibility mask.
- Watchdog (`TIMEOUT`>0):
  - An 8+ bit counter, wide enough for `TIMEOUT`, increments each BUSY cycle without `mem_ready`.
  - When the count reaches `TIMEOUT`: pulse `err`, pulse no valid, set `mem_req`=0, go to IDLE. The requester remains requesting and is re-arbitrated normally.
- `mem_ready` in IDLE is ignored.
- Reset:
  - Any state goes to IDLE.
  - Clears `discard`, the counter and `last_grant` (to IF).
  - The in-flight transaction is dropped; the memory is reset by the same `reset`.

## Timing
- Reset values: `mem_req`, `mem_we`, `if_valid`, `dm_valid` and `err` are 0; `mem_addr`, `mem_wdata`, `if_rdata` and `dm_rdata` are 32'h0.
- All outputs are registered.
- Cycle-level latency, request to valid:
  - Request seen in IDLE at cycle N.
  - `mem_req`=1 in cycle N+1.
  - With `mem_ready` at cycle N+k (k≥1), valid is high in N+k+1, and `mem_req`=0 in N+k+1.
  - Minimum latency is 2 cycles.
- Back-to-back:
  - The cycle after a completion is IDLE with the completer masked.
  - The other requester may be granted in that cycle.
  - Otherwise the completer is re-granted one cycle later, with at most one extra idle cycle.
  - No duplicate transaction is ever issued for a single request.
- `mem_addr`, `mem_we` and `mem_wdata` are stable throughout BUSY.

## Test plan
- DM load alone:
  - Stimulus: `dm_req`=1, `dm_addr`=0x100, with `mem_ready` in the first BUSY cycle returning 0xDEADBEEF.
  - Required: `mem_req`=1 for exactly 1 cycle, then `dm_valid` pulses once with `dm_rdata`=0xDEADBEEF, 2 cycles after the request.
- Simultaneous requests from reset:
  - Stimulus: `if_req` and `dm_req` both asserted, with memory latency 1.
  - Required: grant order DM, IF, DM, IF; each valid pulses once per transaction; `mem_addr` alternates between the two addresses.
- Store:
  - Stimulus: `dm_we`=1, `dm_wdata`=0x12345678, `dm_addr`=0x40, with `mem_ready` after 3 cycles.
  - Required: `mem_we`=1 and `mem_wdata`=0x12345678 held for 3 cycles; `dm_valid` pulses; `dm_rdata` is unchanged.
- Fetch flush:
  - Stimulus: `if_flush` one cycle after grant of fetch 0x200, `mem_ready` 2 cycles later, and a new `if_addr`=0x300 request.
  - Required: no `if_valid` for 0x200; the next grant issues 0x300 and `if_valid` returns its data.
- Watchdog:
  - Stimulus: `TIMEOUT`=4, `dm_req` with `mem_ready` held at 0.
  - Required: `err` pulses after 4 BUSY cycles, `mem_req` drops, there is no `dm_valid`, and the request is re-granted the next cycle.
- Reset mid-BUSY_IF:
  - Stimulus: assert `reset` during BUSY_IF.
  - Required: the next cycle has all outputs at their reset values; a `mem_ready` arriving after reset produces no valid pulse.
